// File: rtl/riscv_v_ext_seq.sv
// Beat sequencer for vzext/vsext.vfN: slices one source register into N extend-unit beats and streams them to writeback.
// Optional perf counters are built when RISCV_V_EXT_SEQ_PERF_EN is defined.
module riscv_v_ext_seq #(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned NUM_OSIZES = 5,
  parameter int unsigned VREG_IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_zero_ext,
  input  logic                  req_is_sign_ext,
  input  logic [2:0]            req_factor_log2,
  input  logic [NUM_OSIZES-1:0] req_dst_osize_vector,
  input  logic [VLEN-1:0]       req_src,
  input  logic [VREG_IDX_W-1:0] req_vd,
  output logic                  req_err,
  output logic                  ext_is_zero_ext,
  output logic                  ext_is_sign_ext,
  output logic [NUM_OSIZES-1:0] ext_src_osize_vector,
  output logic [NUM_OSIZES-1:0] ext_dst_osize_vector,
  output logic [VLEN-1:0]       ext_src_data,
  input  logic [VLEN-1:0]       ext_result,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [VLEN-1:0]       wb_data,
  output logic [VREG_IDX_W-1:0] wb_vd,
  output logic                  wb_last
`ifdef RISCV_V_EXT_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int unsigned OS_IDX_W = (NUM_OSIZES > 1) ? $clog2(NUM_OSIZES) : 1;
  localparam int unsigned SH_W     = $clog2(VLEN);
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        last_cnt;
  logic [SH_W-1:0]         slice_w;
  logic [VREG_IDX_W-1:0]   vd_q;

  logic [OS_IDX_W-1:0]     dst_idx;
  logic                    req_legal;
  logic [NUM_OSIZES-1:0]   req_src_osize;

  // Request decode: destination size index, legality and derived source size
  always_comb begin
    dst_idx = '0;
    for (int unsigned i = 0; i < NUM_OSIZES; i++) begin
      if (req_dst_osize_vector[i]) dst_idx = OS_IDX_W'(i);
    end
    req_legal = (req_is_zero_ext ^ req_is_sign_ext)
             && $onehot(req_dst_osize_vector)
             && (req_factor_log2 >= 3'd1)
             && (req_factor_log2 <= 3'd4)
             && (32'(dst_idx) >= 32'(req_factor_log2));
    req_src_osize = NUM_OSIZES'(1) << (dst_idx - OS_IDX_W'(req_factor_log2));
  end

  // Sequencer FSM; ext_src_data shifts down one slice per captured beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      last_cnt             <= '0;
      slice_w              <= '0;
      vd_q                 <= '0;
      req_ready            <= 1'b1;
      req_err              <= 1'b0;
      ext_is_zero_ext      <= 1'b0;
      ext_is_sign_ext      <= 1'b0;
      ext_src_osize_vector <= '0;
      ext_dst_osize_vector <= '0;
      ext_src_data         <= '0;
      wb_valid             <= 1'b0;
      wb_last              <= 1'b0;
      wb_data              <= '0;
      wb_vd                <= '0;
    end else begin
      req_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_legal) begin
              state                <= RUN;
              req_ready            <= 1'b0;
              cnt                  <= '0;
              last_cnt             <= CNT_W'((32'd1 << req_factor_log2) - 32'd1);
              slice_w              <= SH_W'(VLEN >> req_factor_log2);
              vd_q                 <= req_vd;
              ext_is_zero_ext      <= req_is_zero_ext;
              ext_is_sign_ext      <= req_is_sign_ext;
              ext_src_osize_vector <= req_src_osize;
              ext_dst_osize_vector <= req_dst_osize_vector;
              ext_src_data         <= req_src;
            end else begin
              req_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!wb_valid || wb_ready) begin
            wb_valid     <= 1'b1;
            wb_data      <= ext_result;
            wb_vd        <= vd_q + VREG_IDX_W'(cnt);
            wb_last      <= (cnt == last_cnt);
            cnt          <= cnt + CNT_W'(1);
            ext_src_data <= ext_src_data >> slice_w;
            if (cnt == last_cnt) begin
              state                <= DONE;
              ext_is_zero_ext      <= 1'b0;
              ext_is_sign_ext      <= 1'b0;
              ext_src_osize_vector <= '0;
              ext_dst_osize_vector <= '0;
              ext_src_data         <= '0;
            end
          end
        end
        DONE: begin
          if (wb_ready) begin
            wb_valid  <= 1'b0;
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef RISCV_V_EXT_SEQ_PERF_EN
  // Busy and writeback-stall cycle counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state != IDLE) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (wb_valid && !wb_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
